// File: rtl/serv_pc_ctrl_if.sv
// ---------------------------------------------------------------------------
// serv_pc_ctrl_if
//   Bundle between the state/decode side (master) and the digit-serial PC
//   unit (slave).
//
//   Handshake: i_pc_en acts as the valid for one digit. There is no ready
//   because the PC unit consumes a digit in every cycle where i_pc_en is high.
//   o_rd is valid only in a cycle with i_pc_en high. o_done marks the cycle in
//   which the last digit of an update is consumed. o_ibus_adr and o_bad_pc are
//   registered and show the new values from the following cycle.
//
//   Signals (W = digit width):
//     i_pc_en, i_jump, i_jal_or_jalr, i_utype, i_pc_rel, i_trap, i_iscomp : 1
//     i_imm, i_buf, i_csr_pc : W   (LSB-first digits)
//     o_rd                   : W   (rd write-back digit)
//     o_done, o_bad_pc       : 1
//     o_ibus_adr             : 32  (current fetch address)
// ---------------------------------------------------------------------------
interface serv_pc_ctrl_if #(
    parameter int W = 1
);
    logic         i_pc_en;
    logic         i_jump;
    logic         i_jal_or_jalr;
    logic         i_utype;
    logic         i_pc_rel;
    logic         i_trap;
    logic         i_iscomp;
    logic [W-1:0] i_imm;
    logic [W-1:0] i_buf;
    logic [W-1:0] i_csr_pc;
    logic [W-1:0] o_rd;
    logic         o_done;
    logic         o_bad_pc;
    logic [31:0]  o_ibus_adr;

    modport master (
        output i_pc_en, i_jump, i_jal_or_jalr, i_utype, i_pc_rel, i_trap,
               i_iscomp, i_imm, i_buf, i_csr_pc,
        input  o_rd, o_done, o_bad_pc, o_ibus_adr
    );

    modport slave (
        input  i_pc_en, i_jump, i_jal_or_jalr, i_utype, i_pc_rel, i_trap,
               i_iscomp, i_imm, i_buf, i_csr_pc,
        output o_rd, o_done, o_bad_pc, o_ibus_adr
    );
endinterface

// File: rtl/serv_pc_ctrl.sv
// ---------------------------------------------------------------------------
// serv_pc_ctrl
//   Digit-serial program-counter unit, W bits per cycle (W = 1, 2, 4, 8).
//   Holds the fetch address and computes the next PC (PC+4, PC+2, jump or
//   branch target, trap vector) one digit per enabled cycle, LSB first. It
//   also serialises the rd value for JAL/JALR/AUIPC/LUI.
//
//   Ports:
//     clk   : clock
//     i_rst : synchronous active-high reset (overrides i_pc_en)
//     bus   : serv_pc_ctrl_if.slave (digit inputs, o_rd, o_done,
//             o_bad_pc, o_ibus_adr)
// ---------------------------------------------------------------------------
module serv_pc_ctrl #(
    parameter int          W        = 1,
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter bit          WITH_C   = 1'b1
) (
    input  logic            clk,
    input  logic            i_rst,
    serv_pc_ctrl_if.slave   bus
);
    localparam int D  = 32 / W;
    localparam int CW = $clog2(D);
    // Position of PC bit 1: which digit holds it and where within that digit.
    localparam int B1_DIG = 1 / W;
    localparam int B1_BIT = 1 % W;

    logic [CW-1:0] cnt;
    logic          cy4_r;
    logic          cyo_r;
    logic [31:0]   adr_r;
    logic          bad_r;
    logic          b1_r;

    logic          last;
    logic [W-1:0]  pc;
    logic [31:0]   inc_word;
    logic [W-1:0]  inc_digit;
    logic [W:0]    sum4;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
    logic [W:0]    sumo;
    logic [W-1:0]  tgt_al;
    logic [W-1:0]  csr_al;
    logic [W-1:0]  new_d;
    int            sh;

    assign last = (cnt == CW'(D - 1));
    // The address register shifts right each digit, so its low digit is
    // always the PC digit currently being processed.
    assign pc   = adr_r[W-1:0];

    always_comb begin
        sh        = 0;
        inc_word  = 32'd4;
        inc_digit = '0;
        sum4      = '0;
        opa       = '0;
        opb       = '0;
        sumo      = '0;
        tgt_al    = '0;
        csr_al    = '0;
        new_d     = '0;

        sh        = int'(cnt) * W;
        inc_word  = (WITH_C && bus.i_iscomp) ? 32'd2 : 32'd4;
        inc_digit = W'(inc_word >> sh);
        sum4      = {1'b0, pc} + {1'b0, inc_digit} + {{W{1'b0}}, cy4_r};

        opa = bus.i_pc_rel ? pc : '0;
        opb = bus.i_utype ? bus.i_imm : bus.i_buf;
        // U-type immediates carry only bits [31:12].
        if (bus.i_utype) begin
            for (int i = 0; i < W; i++) begin
                if (sh + i < 12) opb[i] = 1'b0;
            end
        end
        sumo = {1'b0, opa} + {1'b0, opb} + {{W{1'b0}}, cyo_r};

        tgt_al = sumo[W-1:0];
        csr_al = bus.i_csr_pc;
        if (cnt == '0) begin
            tgt_al[0] = 1'b0;
            csr_al[0] = 1'b0;
        end

        if (bus.i_trap)      new_d = csr_al;
        else if (bus.i_jump) new_d = tgt_al;
        else                 new_d = sum4[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            cnt   <= '0;
            cy4_r <= 1'b0;
            cyo_r <= 1'b0;
            adr_r <= RESET_PC;
            bad_r <= 1'b0;
            b1_r  <= 1'b0;
        end else if (bus.i_pc_en) begin
            cnt   <= last ? '0 : cnt + CW'(1);
            // Carries never leak into the next update; this also drops the
            // final carry on 32-bit wrap-around.
            cy4_r <= sum4[W] & ~last;
            cyo_r <= sumo[W] & ~last;
            adr_r <= {new_d, adr_r[31:W]};
            // Bit 1 of the target may be in an earlier digit than the one
            // that raises o_done, so keep it until the update completes.
            if (cnt == CW'(B1_DIG)) b1_r <= tgt_al[B1_BIT];
            if (last) bad_r <= bus.i_jump & ~bus.i_trap & ~WITH_C & b1_r;
        end
    end

    assign bus.o_rd       = ({W{bus.i_utype}} & tgt_al)
                          | ({W{bus.i_jal_or_jalr}} & sum4[W-1:0]);
    assign bus.o_done     = last & bus.i_pc_en;
    assign bus.o_bad_pc   = bad_r;
    assign bus.o_ibus_adr = adr_r;
endmodule

// File: tb/tb_serv_pc_ctrl.sv
module tb_serv_pc_ctrl;
  // clock / reset
  logic clk = 1'b0;
  logic rst_all = 1'b1;
  always #5 clk = ~clk;

  // flags: {jump, jal, utype, pc_rel, trap, iscomp}
  localparam logic [5:0] J   = 6'b100000;
  localparam logic [5:0] JAL = 6'b010000;
  localparam logic [5:0] UT  = 6'b001000;
  localparam logic [5:0] REL = 6'b000100;
  localparam logic [5:0] TR  = 6'b000010;
  localparam logic [5:0] CMP = 6'b000001;

  typedef struct packed {
    logic        jump;
    logic        jal;
    logic        utype;
    logic        pc_rel;
    logic        trap;
    logic        iscomp;
    logic [31:0] imm;
    logic [31:0] bufv;
    logic [31:0] csr;
    int          stall_at;
    int          stall_len;
    int          rst_at;
  } cmd_t;

  function automatic cmd_t mk(input logic [5:0] f, input logic [31:0] imm,
                              input logic [31:0] bufv, input logic [31:0] csr);
    cmd_t c;
    {c.jump, c.jal, c.utype, c.pc_rel, c.trap, c.iscomp} = f;
    c.imm = imm; c.bufv = bufv; c.csr = csr;
    c.stall_at = -1; c.stall_len = 0; c.rst_at = -1;
    return c;
  endfunction

  function automatic int cfg_w(input int k);
    case (k)
      0: return 1;
      1: return 4;
      2: return 2;
      default: return 8;
    endcase
  endfunction

  function automatic logic [31:0] cfg_rst(input int k);
    case (k)
      0: return 32'h0000_0100;
      1: return 32'h0000_2FFE;
      2: return 32'h0000_0000;
      default: return 32'h0000_1000;
    endcase
  endfunction

  function automatic bit cfg_c(input int k);
    return (k != 3);
  endfunction

  // scoreboard: {k[1:0], bad_pc, rd[31:0], adr[31:0]}
  logic [66:0] exp_q[$];
  int total = 0;
  int bad = 0;
  cmd_t cmd = mk(6'b0, 32'h0, 32'h0, 32'h0);
  int go_cnt[4] = '{0, 0, 0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : u
    localparam int WV = cfg_w(g);
    localparam int DV = 32 / WV;
    serv_pc_ctrl_if #(.W(WV)) bus ();
    logic rst_mid;
    logic en;
    int dcnt;
    int go_seen;
    int fin_cnt;
    logic [31:0] rd_acc;
    int seen;
    logic [66:0] e;

    serv_pc_ctrl #(.W(WV), .RESET_PC(cfg_rst(g)), .WITH_C(cfg_c(g))) dut (
      .clk   (clk),
      .i_rst (rst_all | rst_mid),
      .bus   (bus.slave)
    );

    assign bus.i_pc_en       = en;
    assign bus.i_jump        = cmd.jump;
    assign bus.i_jal_or_jalr = cmd.jal;
    assign bus.i_utype       = cmd.utype;
    assign bus.i_pc_rel      = cmd.pc_rel;
    assign bus.i_trap        = cmd.trap;
    assign bus.i_iscomp      = cmd.iscomp;
    assign bus.i_imm         = WV'(cmd.imm  >> (dcnt * WV));
    assign bus.i_buf         = WV'(cmd.bufv >> (dcnt * WV));
    assign bus.i_csr_pc      = WV'(cmd.csr  >> (dcnt * WV));

    // driver: one digit per enabled cycle, optional stall / mid-update reset
    initial begin
      en = 1'b0; rst_mid = 1'b0; dcnt = 0; go_seen = 0; fin_cnt = 0;
      forever begin
        @(negedge clk);
        if (go_cnt[g] > go_seen) begin
          go_seen++;
          for (int d = 0; d < DV; d++) begin
            if (d == cmd.rst_at) begin
              rst_mid = 1'b1;
              @(negedge clk);
              rst_mid = 1'b0;
              break;
            end
            dcnt = d;
            en = 1'b1;
            @(negedge clk);
            en = 1'b0;
            if (d == cmd.stall_at) repeat (cmd.stall_len) @(negedge clk);
          end
          fin_cnt++;
        end
      end
    end

    // monitor: checks o_done each digit, pops on each completed update
    initial begin
      seen = 0; rd_acc = '0; e = '0;
      forever begin
        @(negedge clk);
        #2;
        if (rst_all || rst_mid) begin
          seen = 0;
        end else if (bus.i_pc_en) begin
          rd_acc = {bus.o_rd, rd_acc[31:WV]};
          chk($sformatf("u%0d.done_d%0d", g, seen), 32'(bus.o_done), 32'(seen == DV - 1));
          if (seen == DV - 1) begin
            seen = 0;
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
              chk($sformatf("u%0d.unexpected_done", g), 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              chk($sformatf("u%0d.inst", g), 32'(g), 32'(e[66:65]));
              chk($sformatf("u%0d.adr", g), bus.o_ibus_adr, e[31:0]);
              chk($sformatf("u%0d.rd", g), rd_acc, e[63:32]);
              chk($sformatf("u%0d.bad_pc", g), 32'(bus.o_bad_pc), 32'(e[64]));
            end
          end else begin
            seen++;
          end
        end
      end
    end
  end

  function automatic int fin_of(input int k);
    case (k)
      0: return u[0].fin_cnt;
      1: return u[1].fin_cnt;
      2: return u[2].fin_cnt;
      default: return u[3].fin_cnt;
    endcase
  endfunction

  task automatic issue(input int k, input cmd_t c, input logic has_exp,
                       input logic [31:0] e_adr, input logic [31:0] e_rd, input logic e_bad);
    int target;
    cmd = c;
    if (has_exp) exp_q.push_back({2'(k), e_bad, e_rd, e_adr});
    target = fin_of(k) + 1;
    go_cnt[k]++;
    for (int t = 0; t < 400 && fin_of(k) < target; t++) @(negedge clk);
    if (fin_of(k) < target) chk($sformatf("u%0d.timeout", k), 32'd1, 32'd0);
  endtask

  cmd_t c;

  initial begin
    repeat (3) @(negedge clk);
    rst_all = 1'b0;
    @(negedge clk);
    chk("u0.rst_adr", u[0].bus.o_ibus_adr, 32'h0000_0100);
    chk("u1.rst_adr", u[1].bus.o_ibus_adr, 32'h0000_2FFE);
    chk("u2.rst_adr", u[2].bus.o_ibus_adr, 32'h0000_0000);
    chk("u3.rst_adr", u[3].bus.o_ibus_adr, 32'h0000_1000);
    chk("u0.rst_bad", 32'(u[0].bus.o_bad_pc), 32'd0);
    chk("u3.rst_bad", 32'(u[3].bus.o_bad_pc), 32'd0);

    // W=1: plain +4, aligned jump target, compressed jal
    issue(0, mk(6'b0, 0, 0, 0), 1, 32'h0000_0104, 32'h0, 1'b0);
    issue(0, mk(J, 0, 32'h0000_0203, 0), 1, 32'h0000_0202, 32'h0, 1'b0);
    issue(0, mk(JAL | CMP, 0, 0, 0), 1, 32'h0000_0204, 32'h0000_0204, 1'b0);

    // W=4: +2 ripple, absolute jump, jal pc-relative, auipc, lui
    issue(1, mk(CMP, 0, 0, 0), 1, 32'h0000_3000, 32'h0, 1'b0);
    issue(1, mk(J, 0, 32'h0000_1000, 0), 1, 32'h0000_1000, 32'h0, 1'b0);
    issue(1, mk(J | JAL | REL, 0, 32'h0000_0080, 0), 1, 32'h0000_1080, 32'h0000_1004, 1'b0);
    issue(1, mk(UT | REL, 32'h1234_5678, 0, 0), 1, 32'h0000_1084, 32'h1234_6080, 1'b0);
    issue(1, mk(UT, 32'hABCD_EFFF, 0, 0), 1, 32'h0000_1088, 32'hABCD_E000, 1'b0);

    // W=2: trap, trap beats jump, stalled jump, reset mid-update
    issue(2, mk(TR, 0, 0, 32'h8000_0001), 1, 32'h8000_0000, 32'h0, 1'b0);
    issue(2, mk(TR | J, 0, 32'h0000_0010, 32'h0000_0201), 1, 32'h0000_0200, 32'h0, 1'b0);
    c = mk(J | REL, 0, 32'h0000_0100, 0);
    c.stall_at = 7; c.stall_len = 5;
    issue(2, c, 1, 32'h0000_0300, 32'h0, 1'b0);
    c = mk(J | REL, 0, 32'h0000_0100, 0);
    c.rst_at = 9;
    issue(2, c, 0, 32'h0, 32'h0, 1'b0);
    chk("u2.mid_rst_adr", u[2].bus.o_ibus_adr, 32'h0000_0000);
    chk("u2.mid_rst_bad", 32'(u[2].bus.o_bad_pc), 32'd0);
    issue(2, mk(6'b0, 0, 0, 0), 1, 32'h0000_0004, 32'h0, 1'b0);

    // W=8, no compressed: misaligned target, sequential clear, wrap-around
    issue(3, mk(J, 0, 32'h0000_1002, 0), 1, 32'h0000_1002, 32'h0, 1'b1);
    issue(3, mk(6'b0, 0, 0, 0), 1, 32'h0000_1006, 32'h0, 1'b0);
    issue(3, mk(J, 0, 32'hFFFF_FFFC, 0), 1, 32'hFFFF_FFFC, 32'h0, 1'b0);
    issue(3, mk(6'b0, 0, 0, 0), 1, 32'h0000_0000, 32'h0, 1'b0);
    issue(3, mk(CMP, 0, 0, 0), 1, 32'h0000_0004, 32'h0, 1'b0);
    issue(3, mk(J | JAL | REL, 0, 32'hFFFF_FFFC, 0), 1, 32'h0000_0000, 32'h0000_0008, 1'b0);

    repeat (4) @(negedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
